fetch_stage: RTL
================

# fetch_stage

Instruction-fetch (F) stage of the five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory word address, range-checks the fetch address, and registers the fetched instruction into the F/D pipeline register. It feeds the D stage and takes its next PC from the next-PC selector (`npc`), which consumes `F_pc` and produces `npc` combinationally each cycle.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_3000, PC value after reset.
- `IM_BASE`, 32'h0000_3000, byte address of instruction-memory word 0.
- `IM_AW`, 12, instruction-memory word-address width; memory holds 2^IM_AW words.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  from hazard unit; freezes PC and F/D register.
- `flush`  in  1  loads a bubble into F/D.
- `npc`  in  32  next PC from the next-PC selector.
- `im_rdata`  in  32  instruction word at `im_addr` (combinational read).
- `F_pc`  out  32  current PC; also goes to the next-PC selector.
- `im_addr`  out  IM_AW  word index into instruction memory.
- `D_instr`  out  32  registered instruction for D.
- `D_pc`  out  32  registered PC of `D_instr`.
- `D_pc8`  out  32  `D_pc + 8` (jal/jalr link value), registered.
- `D_valid`  out  1  F/D holds a real instruction (0 = bubble).
- `D_exc`  out  1  instruction in D came from an illegal fetch address.

## Operation
- Fetch-error check, combinational on `F_pc`: `f_err = (F_pc[1:0] != 0) | (F_pc < IM_BASE) | (F_pc >= IM_BASE + 4*2^IM_AW)`. Comparisons unsigned, 33-bit, so the upper bound does not wrap.
- `im_addr = (F_pc - IM_BASE)[IM_AW+1:2]`. Driven even when `f_err`; its value is don't-care then.
- `fetched = f_err ? 32'h0000_0000 : im_rdata`. An illegal fetch becomes a nop.
- Per rising edge, priority reset > stall > normal:
  - reset: `F_pc <= PC_INIT`; `D_instr`, `D_pc`, `D_pc8` <= 0; `D_valid` <= 0; `D_exc` <= 0.
  - stall=1: every register holds. `flush` is ignored in that cycle. The hazard unit must not assert both.
  - stall=0, flush=0: `F_pc <= npc`; `D_instr <= fetched`; `D_pc <= F_pc`; `D_pc8 <= F_pc + 8`; `D_valid <= 1`; `D_exc <= f_err`.
  - stall=0, flush=1: `F_pc <= npc`; `D_instr`, `D_pc8`, `D_exc` <= 0; `D_pc <= F_pc` (kept for debug); `D_valid <= 0`.
- The delay slot is architectural. A branch in D does not flush F; the delay-slot instruction always reaches D.
- Arithmetic is mod 2^32. `F_pc + 8` wraps silently.
- Reset asserted mid-stall or mid-flush wins unconditionally. The cycle after reset is released, `F_pc = PC_INIT` and `D_valid = 0`.

## Timing
- `F_pc`, all `D_*` outputs: registered, change only on a clock edge.
- `im_addr` and `f_err` are combinational from `F_pc` and valid within the same cycle.
- Latency: PC→F/D is 1 cycle. An instruction fetched at `F_pc` in cycle n is visible on `D_instr` in cycle n+1.
- `npc` is sampled at the edge ending the cycle. A `npc` that depends on `D_instr` (branch/jump resolved in D) redirects the fetch one instruction after the branch, which is the delay slot.
- Stall held for k cycles: `F_pc` and `D_*` stay constant for k edges. The first non-stalled edge performs a normal update using the `npc` of that cycle.

## Test plan
- Reset then free-run with `npc = F_pc + 4` and memory word i = 0x1000_0000+i → `F_pc` goes 0x3000, 0x3004, 0x3008. One cycle after reset release `D_valid = 0`. The next edge gives `D_instr = 0x1000_0000`, `D_pc = 0x3000`, `D_pc8 = 0x3008`.
- Assert `stall` for 3 cycles with `F_pc = 0x3010` → `F_pc` stays 0x3010 and `D_instr`/`D_pc` are unchanged for 3 edges. On release the next edge gives `D_pc = 0x3010`.
- Pulse `flush` with `F_pc = 0x3020` → next cycle `D_valid = 0`, `D_instr = 0`, `D_exc = 0`, and `F_pc` = `npc`.
- Drive `npc` = 0x3002, then 0x2FFC, then 0x7000 (IM_AW=12) → each following D cycle has `D_instr = 0` and `D_exc = 1`, with `D_pc` equal to the bad address.
- Reset asserted while `stall = 1` and `F_pc = 0x3040` → next cycle `F_pc = 0x3000`, all `D_*` outputs 0.
- Jump to the last word 0x6FFC, then `npc = F_pc + 4` → 0x6FFC fetches normally with `D_exc = 0`. 0x7000 gives `D_exc = 1` and `D_instr = 0`.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the PC, drives the instruction-memory word address, range-checks the
// fetch address and registers the fetched word into the F/D pipeline register.
//
// Pipeline control: stall and flush are level signals sampled at the rising
// edge. stall=1 holds every register (flush ignored that cycle); stall=0 with
// flush=1 advances the PC and loads a bubble into F/D; stall=0 with flush=0
// advances the PC and loads the fetched instruction. reset overrides both.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter logic [31:0] IM_BASE = 32'h0000_3000,
    parameter int          IM_AW   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      npc,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      F_pc,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      D_instr,
    output logic [31:0]      D_pc,
    output logic [31:0]      D_pc8,
    output logic             D_valid,
    output logic             D_exc
);

    // One past the last legal byte address; 33 bits so it cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_AW);

    logic              f_err;
    logic [IM_AW+1:0]  im_offset;
    logic [31:0]       fetched;

    // Fetch-address check and memory word index, both combinational on F_pc.
    // Only the low IM_AW+2 bits of the offset matter, and subtraction mod
    // 2^(IM_AW+2) yields the same bits as the full 32-bit subtraction.
    always_comb begin
        f_err     = (F_pc[1:0] != 2'b00)
                  | ({1'b0, F_pc} <  {1'b0, IM_BASE})
                  | ({1'b0, F_pc} >= IM_END);
        im_offset = F_pc[IM_AW+1:0] - IM_BASE[IM_AW+1:0];
        im_addr   = im_offset[IM_AW+1:2];
        fetched   = f_err ? 32'h0000_0000 : im_rdata;
    end

    // PC register and F/D pipeline register: reset > stall > flush > normal.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc    <= PC_INIT;
            D_instr <= 32'h0000_0000;
            D_pc    <= 32'h0000_0000;
            D_pc8   <= 32'h0000_0000;
            D_valid <= 1'b0;
            D_exc   <= 1'b0;
        end else if (!stall) begin
            F_pc <= npc;
            D_pc <= F_pc;
            if (flush) begin
                D_instr <= 32'h0000_0000;
                D_pc8   <= 32'h0000_0000;
                D_valid <= 1'b0;
                D_exc   <= 1'b0;
            end else begin
                D_instr <= fetched;
                D_pc8   <= F_pc + 32'd8;
                D_valid <= 1'b1;
                D_exc   <= f_err;
            end
        end
    end

endmodule
